// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with load, enable, step, wrap or saturate
// range handling, and a count-state FSM (IDLE / CNT_UP / CNT_DN / HELD).
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 255,
    parameter int SAT_MODE = 0,
    parameter int DIR_SRC  = 0,
    parameter int RST_VAL  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  A,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  Q,
    output logic              dir_o,
    output logic              wrap_o,
    output logic              at_max,
    output logic              at_min,
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {IDLE, CNT_UP, CNT_DN, HELD} state_t;
    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] RNG_W = WIDTH'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic signed [XW-1:0] MAX_X = XW'(MAX_VAL);
    localparam logic signed [XW-1:0] MIN_X = XW'(MIN_VAL);

    state_t state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic dir_q, dir_d, wrap_q, wrap_d;
    logic dir_up, over, under, frozen;
    logic signed [XW-1:0] sum_x;

    assign dir_up = (DIR_SRC != 0) ? up_dn : ~A[0];
    // Two guard bits keep the raw sum exact so range violations are visible before folding.
    assign sum_x  = dir_up ? $signed({2'b00, q_q}) + $signed(XW'(step))
                           : $signed({2'b00, q_q}) - $signed(XW'(step));
    assign over   = sum_x > MAX_X;
    assign under  = sum_x < MIN_X;
    assign at_max = q_q == MAX_W;
    assign at_min = q_q == MIN_W;
    assign frozen = (state_q == HELD) && (dir_up ? at_max : at_min);

    always_comb begin
        q_d     = q_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        state_d = (state_q == HELD) ? HELD : IDLE;
        if (load) begin
            q_d     = (A > MAX_W) ? MAX_W : (A < MIN_W) ? MIN_W : A;
            state_d = IDLE;
        end else if (en) begin
            dir_d = dir_up;
            if (!frozen) begin
                state_d = dir_up ? CNT_UP : CNT_DN;
                if (step != '0) begin
                    q_d    = over  ? ((SAT_MODE != 0) ? MAX_W : sum_x[WIDTH-1:0] - RNG_W) :
                             under ? ((SAT_MODE != 0) ? MIN_W : sum_x[WIDTH-1:0] + RNG_W) :
                             sum_x[WIDTH-1:0];
                    wrap_d = over | under;
                    if (SAT_MODE != 0 && state_q != HELD && q_d == (dir_up ? MAX_W : MIN_W))
                        state_d = HELD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RST_W;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            q_q     <= q_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
        end
    end

    assign Q       = q_q;
    assign dir_o   = dir_q;
    assign wrap_o  = wrap_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: three counter configurations driven in parallel and compared each
// cycle against an integer-arithmetic reference model, plus directed scenario checks.
module tb_updown_counter_param;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, up_dn = 1'b0;
    logic [7:0] A = '0;
    logic [3:0] step = '0;
    logic [7:0] q_a[3];
    logic dir_a[3], wrap_a[3], amax_a[3], amin_a[3];
    logic [1:0] st_a[3];
    int checks = 0, failures = 0;
    int mn[3]  = '{0, 0, 10};
    int mx[3]  = '{255, 200, 100};
    int sat[3] = '{0, 1, 0};
    int ds[3]  = '{0, 0, 1};
    int rv[3]  = '{0, 0, 50};
    int mq[3], md[3], mw[3], ms[3];

    always #5 clk = ~clk;

    updown_counter_param u0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .A(A), .up_dn(up_dn), .step(step),
        .Q(q_a[0]), .dir_o(dir_a[0]), .wrap_o(wrap_a[0]), .at_max(amax_a[0]), .at_min(amin_a[0]),
        .state_o(st_a[0]));
    updown_counter_param #(.MAX_VAL(200), .SAT_MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .A(A), .up_dn(up_dn), .step(step),
        .Q(q_a[1]), .dir_o(dir_a[1]), .wrap_o(wrap_a[1]), .at_max(amax_a[1]), .at_min(amin_a[1]),
        .state_o(st_a[1]));
    updown_counter_param #(.MIN_VAL(10), .MAX_VAL(100), .DIR_SRC(1), .RST_VAL(50)) u2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .A(A), .up_dn(up_dn), .step(step),
        .Q(q_a[2]), .dir_o(dir_a[2]), .wrap_o(wrap_a[2]), .at_max(amax_a[2]), .at_min(amin_a[2]),
        .state_o(st_a[2]));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all();
        for (int k = 0; k < 3; k++) begin
            chk("Q", k, 32'(q_a[k]), mq[k]);
            chk("dir_o", k, 32'(dir_a[k]), md[k]);
            chk("wrap_o", k, 32'(wrap_a[k]), mw[k]);
            chk("state_o", k, 32'(st_a[k]), ms[k]);
            chk("at_max", k, 32'(amax_a[k]), 32'(mq[k] == mx[k]));
            chk("at_min", k, 32'(amin_a[k]), 32'(mq[k] == mn[k]));
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            mq[k] = rv[k]; md[k] = 1; mw[k] = 0; ms[k] = 0;
        end
    endtask

    // States: 0 idle, 1 counting up, 2 counting down, 3 held at a bound.
    task automatic upd(input int k);
        int d, t, c;
        if (load) begin
            mq[k] = (int'(A) > mx[k]) ? mx[k] : (int'(A) < mn[k]) ? mn[k] : int'(A);
            mw[k] = 0;
            ms[k] = 0;
        end else if (en) begin
            d = ds[k] != 0 ? int'(up_dn) : int'(!A[0]);
            md[k] = d;
            mw[k] = 0;
            if (!(ms[k] == 3 && mq[k] == (d != 0 ? mx[k] : mn[k]))) begin
                if (step == 0) ms[k] = d != 0 ? 1 : 2;
                else begin
                    t = mq[k] + (d != 0 ? int'(step) : -int'(step));
                    if (sat[k] != 0) begin
                        c = (t > mx[k]) ? mx[k] : (t < mn[k]) ? mn[k] : t;
                        mw[k] = int'(c != t);
                        ms[k] = (ms[k] != 3 && c == (d != 0 ? mx[k] : mn[k])) ? 3 : (d != 0 ? 1 : 2);
                        mq[k] = c;
                    end else begin
                        mw[k] = int'(t > mx[k] || t < mn[k]);
                        mq[k] = (t > mx[k]) ? t - (mx[k] - mn[k] + 1) :
                                (t < mn[k]) ? t + (mx[k] - mn[k] + 1) : t;
                        ms[k] = d != 0 ? 1 : 2;
                    end
                end
            end
        end else begin
            mw[k] = 0;
            ms[k] = (ms[k] == 3) ? 3 : 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) upd(k);
        #1;
        chk_all();
    endtask

    initial begin
        bit bias;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;
        // Count up from reset
        A = 8'h04; step = 4'd1; en = 1'b1;
        cyc(); chk("t2_q1", 0, 32'(q_a[0]), 1);
        cyc(); chk("t2_q2", 0, 32'(q_a[0]), 2);
        cyc(); chk("t2_q3", 0, 32'(q_a[0]), 3);
        chk("t2_dir", 0, 32'(dir_a[0]), 1);
        chk("t2_state", 0, 32'(st_a[0]), 1);
        // Wrap below MIN_VAL
        load = 1'b1; A = 8'h02;
        cyc(); chk("t3_load", 0, 32'(q_a[0]), 2);
        load = 1'b0; A = 8'h05; step = 4'd3;
        cyc(); chk("t3_q", 0, 32'(q_a[0]), 255);
        chk("t3_wrap", 0, 32'(wrap_a[0]), 1);
        en = 1'b0;
        cyc(); chk("t3_wrap_clr", 0, 32'(wrap_a[0]), 0);
        // Saturate into HELD
        load = 1'b1; en = 1'b1; A = 8'd198;
        cyc(); chk("t4_load", 1, 32'(q_a[1]), 198);
        load = 1'b0; A = 8'h04; step = 4'd5;
        cyc(); chk("t4_q", 1, 32'(q_a[1]), 200);
        chk("t4_wrap", 1, 32'(wrap_a[1]), 1);
        chk("t4_state", 1, 32'(st_a[1]), 3);
        cyc(); chk("t4_hold_q", 1, 32'(q_a[1]), 200);
        chk("t4_hold_wrap", 1, 32'(wrap_a[1]), 0);
        en = 1'b0;
        cyc(); chk("t4_en0_state", 1, 32'(st_a[1]), 3);
        // Reverse out of HELD
        en = 1'b1; A = 8'h05; step = 4'd2;
        cyc(); chk("t5_q", 1, 32'(q_a[1]), 198);
        chk("t5_state", 1, 32'(st_a[1]), 2);
        chk("t5_dir", 1, 32'(dir_a[1]), 0);
        // Load overrides enable and clamps
        load = 1'b1; A = 8'hF0;
        cyc(); chk("t6_q", 1, 32'(q_a[1]), 200);
        chk("t6_state", 1, 32'(st_a[1]), 0);
        chk("t6_q_u0", 0, 32'(q_a[0]), 240);
        // Asynchronous reset between edges
        load = 1'b0; A = 8'h04; step = 4'd1;
        cyc();
        #3 rst = 1'b1;
        #1;
        chk("t1_q", 0, 32'(q_a[0]), 0);
        chk("t1_state", 0, 32'(st_a[0]), 0);
        chk("t1_q_u2", 2, 32'(q_a[2]), 50);
        reset_model();
        chk_all();
        #1 rst = 1'b0;
        // Randomised phases with a drifting direction bias so bounds get hit
        for (int i = 0; i < 600; i++) begin
            bias = 1'((i / 60) % 2);
            load = $urandom_range(0, 19) == 0;
            en = $urandom_range(0, 3) != 0;
            A = 8'($urandom);
            A[0] = ($urandom_range(0, 9) < 8) ? bias : ~bias;
            up_dn = ($urandom_range(0, 9) < 8) ? ~bias : bias;
            step = 4'($urandom_range(0, 15));
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
